// File: rtl/tester_gtx_seq_if.sv
// Control/status bundle of the GTX loopback test sequencer.
//   slave  : the sequencer side (takes start/abort/config/err_flag, drives the
//            generator controls, status and error counts)
//   master : the controlling side (VIO replacement, testbench)
// Signals:
//   start, abort       single-cycle requests
//   run_len            RUN length in usrclk cycles, latched on accepted start
//   len_ctrl_in        generator length code, latched on accepted start
//   err_flag           per-channel checker error flags (asynchronous)
//   test_len_ctrl      latched length code to the generator
//   test_run_ctrl      traffic enable to the generator
//   gen_rst_n          active-low reset to generator and checkers
//   busy, done, state  sequencer status
//   fail_mask, err_cnt per-channel results
interface tester_gtx_seq_if #(
    parameter int CHNL_NUM = 8,
    parameter int TICK_W   = 32,
    parameter int ERRCNT_W = 16
);
    logic                         start;
    logic                         abort;
    logic [TICK_W-1:0]            run_len;
    logic [7:0]                   len_ctrl_in;
    logic [CHNL_NUM-1:0]          err_flag;
    logic [7:0]                   test_len_ctrl;
    logic                         test_run_ctrl;
    logic                         gen_rst_n;
    logic                         busy;
    logic                         done;
    logic [CHNL_NUM-1:0]          fail_mask;
    logic [CHNL_NUM*ERRCNT_W-1:0] err_cnt;
    logic [2:0]                   state;

    modport slave (
        input  start, abort, run_len, len_ctrl_in, err_flag,
        output test_len_ctrl, test_run_ctrl, gen_rst_n, busy, done,
               fail_mask, err_cnt, state
    );

    modport master (
        output start, abort, run_len, len_ctrl_in, err_flag,
        input  test_len_ctrl, test_run_ctrl, gen_rst_n, busy, done,
               fail_mask, err_cnt, state
    );
endinterface

// File: rtl/tester_gtx_seq.sv
// Test sequencer for the multi-channel GTX loopback tester (txusrclk2 domain).
// On an accepted start it holds the generator/checkers in reset, waits for the
// links to settle, enables traffic for run_len cycles, then drains, while
// counting per-channel checker error edges during RUN and DRAIN.
// Ports:
//   usrclk  txusrclk2, the only clock
//   usrrst  asynchronous active-high reset
//   bus     tester_gtx_seq_if.slave (requests, config, error flags, status)
module tester_gtx_seq #(
    parameter int CHNL_NUM   = 8,
    parameter int RST_CYC    = 16,
    parameter int SETTLE_CYC = 1024,
    parameter int DRAIN_CYC  = 64,
    parameter int TICK_W     = 32,
    parameter int ERRCNT_W   = 16
) (
    input  logic              usrclk,
    input  logic              usrrst,
    tester_gtx_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              state_q;
    logic [TICK_W-1:0]   tick_q;
    logic [TICK_W-1:0]   run_len_q;
    logic [7:0]          len_q;
    logic                run_q;
    logic                grst_n_q;
    logic                busy_q;
    logic                done_q;

    logic [CHNL_NUM-1:0] sync1_q;
    logic [CHNL_NUM-1:0] sync2_q;
    logic [CHNL_NUM-1:0] sync3_q;
    logic [CHNL_NUM-1:0] rise;
    logic [ERRCNT_W-1:0] cnt_q [CHNL_NUM];
    logic [CHNL_NUM-1:0] fail_q;

    logic                abort_take;
    logic                start_acc;
    logic                count_en;

    // Abort only acts outside IDLE but still masks a coincident start.
    assign abort_take = bus.abort && (state_q != S_IDLE);
    assign start_acc  = bus.start && !bus.abort &&
                        (state_q == S_IDLE || state_q == S_DONE);
    assign count_en   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign rise       = sync2_q & ~sync3_q;

    // Phase counter loads (length - 1) on entry and the phase ends at zero.
    always_ff @(posedge usrclk or posedge usrrst) begin
        if (usrrst) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            run_len_q <= '0;
            len_q     <= '0;
            run_q     <= 1'b0;
            grst_n_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort_take) begin
            state_q  <= S_IDLE;
            run_q    <= 1'b0;
            grst_n_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_acc) begin
            state_q   <= S_RESET;
            run_len_q <= bus.run_len;
            len_q     <= bus.len_ctrl_in;
            tick_q    <= TICK_W'(RST_CYC - 1);
            run_q     <= 1'b0;
            grst_n_q  <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    grst_n_q <= 1'b1;
                end
                S_RESET: begin
                    if (tick_q == '0) begin
                        state_q  <= S_SETTLE;
                        grst_n_q <= 1'b1;
                        tick_q   <= TICK_W'(SETTLE_CYC - 1);
                    end else begin
                        tick_q <= tick_q - TICK_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (tick_q == '0) begin
                        if (run_len_q != '0) begin
                            state_q <= S_RUN;
                            run_q   <= 1'b1;
                            tick_q  <= run_len_q - TICK_W'(1);
                        end else begin
                            state_q <= S_DRAIN;
                            tick_q  <= TICK_W'(DRAIN_CYC - 1);
                        end
                    end else begin
                        tick_q <= tick_q - TICK_W'(1);
                    end
                end
                S_RUN: begin
                    if (tick_q == '0) begin
                        state_q <= S_DRAIN;
                        run_q   <= 1'b0;
                        tick_q  <= TICK_W'(DRAIN_CYC - 1);
                    end else begin
                        tick_q <= tick_q - TICK_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (tick_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        tick_q <= tick_q - TICK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Two-flop synchronizer, edge-detect flop, saturating per-channel counters.
    always_ff @(posedge usrclk or posedge usrrst) begin
        if (usrrst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            fail_q  <= '0;
            for (int unsigned i = 0; i < CHNL_NUM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= bus.err_flag;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            for (int unsigned i = 0; i < CHNL_NUM; i++) begin
                fail_q[i] <= (cnt_q[i] != '0);
                if (start_acc) begin
                    cnt_q[i] <= '0;
                end else if (count_en && rise[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + ERRCNT_W'(1);
                end
            end
        end
    end

    logic [CHNL_NUM*ERRCNT_W-1:0] err_flat;

    always_comb begin
        err_flat = '0;
        for (int unsigned i = 0; i < CHNL_NUM; i++) begin
            err_flat[i*ERRCNT_W +: ERRCNT_W] = cnt_q[i];
        end
    end

    assign bus.test_len_ctrl = len_q;
    assign bus.test_run_ctrl = run_q;
    assign bus.gen_rst_n     = grst_n_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.fail_mask     = fail_q;
    assign bus.err_cnt       = err_flat;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_tester_gtx_seq.sv
// Directed testbench for tester_gtx_seq with RST_CYC=4, SETTLE_CYC=8,
// DRAIN_CYC=4, ERRCNT_W=4. Cycle numbering: cycle 1 is the first cycle after
// the edge that samples start.
module tb_tester_gtx_seq;

    localparam int CH = 8;
    localparam int TW = 32;
    localparam int EW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    tester_gtx_seq_if #(.CHNL_NUM(CH), .TICK_W(TW), .ERRCNT_W(EW)) bus ();

    tester_gtx_seq #(
        .CHNL_NUM  (CH),
        .RST_CYC   (4),
        .SETTLE_CYC(8),
        .DRAIN_CYC (4),
        .TICK_W    (TW),
        .ERRCNT_W  (EW)
    ) dut (
        .usrclk(clk),
        .usrrst(rst),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected state in cycle c of a run of length r.
    function automatic logic [2:0] exp_state(input int c, input int r);
        if (c <= 4)      return 3'd1;
        if (c <= 12)     return 3'd2;
        if (c <= 12 + r) return 3'd3;
        if (c <= 16 + r) return 3'd4;
        return 3'd5;
    endfunction

    function automatic logic [EW-1:0] cnt_of(input int ch);
        logic [CH*EW-1:0] v;
        v = bus.err_cnt;
        return v[ch*EW +: EW];
    endfunction

    task automatic do_start(input int r, input logic [7:0] len);
        bus.run_len     = TW'(r);
        bus.len_ctrl_in = len;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] st;
        bus.start = 0; bus.abort = 0; bus.run_len = '0;
        bus.len_ctrl_in = '0; bus.err_flag = '0;
        rst = 1'b1;
        tick(); tick();
        st = bus.state;
        nchk++; if (st !== 3'd0) begin nerr++; $display("FAIL reset_state got %0d want 0", st); end
        nchk++; if (bus.gen_rst_n !== 1'b0) begin nerr++; $display("FAIL reset_gen_rst_n got %b want 0", bus.gen_rst_n); end
        nchk++; if (bus.test_run_ctrl !== 1'b0) begin nerr++; $display("FAIL reset_run got %b want 0", bus.test_run_ctrl); end
        nchk++; if (bus.test_len_ctrl !== 8'h00) begin nerr++; $display("FAIL reset_len got %h want 00", bus.test_len_ctrl); end
        nchk++; if ({bus.busy, bus.done} !== 2'b00) begin nerr++; $display("FAIL reset_busy_done got %b want 00", {bus.busy, bus.done}); end
        nchk++; if (bus.err_cnt !== '0) begin nerr++; $display("FAIL reset_err_cnt got %h want 0", bus.err_cnt); end
        nchk++; if (bus.fail_mask !== '0) begin nerr++; $display("FAIL reset_fail_mask got %h want 0", bus.fail_mask); end
        rst = 1'b0;
        tick();
        nchk++; if (bus.gen_rst_n !== 1'b1) begin nerr++; $display("FAIL release_gen_rst_n got %b want 1", bus.gen_rst_n); end
        st = bus.state;
        nchk++; if (st !== 3'd0) begin nerr++; $display("FAIL release_state got %0d want 0", st); end
    endtask

    task automatic test_nominal();
        logic [2:0] es, st;
        do_start(20, 8'h3C);
        nchk++; if (bus.test_len_ctrl !== 8'h3C) begin nerr++; $display("FAIL nom_len got %h want 3c", bus.test_len_ctrl); end
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) tick();
            es = exp_state(c, 20);
            st = bus.state;
            nchk++; if (st !== es) begin nerr++; $display("FAIL nom_state c=%0d got %0d want %0d", c, st, es); end
            nchk++; if (bus.gen_rst_n !== (es != 3'd1)) begin nerr++; $display("FAIL nom_gen_rst_n c=%0d got %b want %b", c, bus.gen_rst_n, es != 3'd1); end
            nchk++; if (bus.test_run_ctrl !== (es == 3'd3)) begin nerr++; $display("FAIL nom_run c=%0d got %b want %b", c, bus.test_run_ctrl, es == 3'd3); end
            nchk++; if (bus.busy !== (es >= 3'd1 && es <= 3'd4)) begin nerr++; $display("FAIL nom_busy c=%0d got %b", c, bus.busy); end
            nchk++; if (bus.done !== (es == 3'd5)) begin nerr++; $display("FAIL nom_done c=%0d got %b want %b", c, bus.done, es == 3'd5); end
        end
        nchk++; if (bus.fail_mask !== '0) begin nerr++; $display("FAIL nom_fail_mask got %h want 0", bus.fail_mask); end
    endtask

    task automatic test_error_inject();
        logic [EW-1:0] v;
        do_start(20, 8'h3C);
        for (int c = 2; c <= 40; c++) begin
            tick();
            bus.err_flag[2] = (c == 6 || c == 7 || c == 15 || c == 16 ||
                               c == 20 || c == 21 || c == 25 || c == 26);
        end
        for (int ch = 0; ch < CH; ch++) begin
            v = cnt_of(ch);
            nchk++;
            if (v !== ((ch == 2) ? EW'(3) : EW'(0))) begin
                nerr++; $display("FAIL inj_cnt ch%0d got %0d want %0d", ch, v, (ch == 2) ? 3 : 0);
            end
        end
        nchk++; if (bus.fail_mask !== 8'h04) begin nerr++; $display("FAIL inj_fail_mask got %h want 04", bus.fail_mask); end
    endtask

    task automatic test_saturation();
        logic [EW-1:0] v;
        do_start(100, 8'h01);
        for (int c = 2; c <= 120; c++) begin
            tick();
            bus.err_flag[0] = (c >= 14 && c <= 91 && ((c - 14) % 4) < 2);
            bus.err_flag[1] = (c >= 13 && c <= 112);
        end
        nchk++; if (bus.done !== 1'b1) begin nerr++; $display("FAIL sat_done got %b want 1", bus.done); end
        for (int ch = 0; ch < CH; ch++) begin
            v = cnt_of(ch);
            nchk++;
            if (v !== ((ch == 0) ? EW'(15) : (ch == 1) ? EW'(1) : EW'(0))) begin
                nerr++; $display("FAIL sat_cnt ch%0d got %0d", ch, v);
            end
        end
        nchk++; if (bus.fail_mask !== 8'h03) begin nerr++; $display("FAIL sat_fail_mask got %h want 03", bus.fail_mask); end
    endtask

    task automatic test_zero_restart();
        logic [2:0] es, st;
        do_start(0, 8'h55);
        nchk++; if (bus.err_cnt !== '0) begin nerr++; $display("FAIL zr_cleared got %h want 0", bus.err_cnt); end
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (c == 2) begin
                nchk++; if (bus.fail_mask !== '0) begin nerr++; $display("FAIL zr_fail_mask got %h want 0", bus.fail_mask); end
            end
            es = exp_state(c, 0);
            st = bus.state;
            nchk++; if (st !== es) begin nerr++; $display("FAIL zr_state c=%0d got %0d want %0d", c, st, es); end
            nchk++; if (bus.test_run_ctrl !== 1'b0) begin nerr++; $display("FAIL zr_run c=%0d got %b want 0", c, bus.test_run_ctrl); end
        end
        nchk++; if (bus.done !== 1'b1) begin nerr++; $display("FAIL zr_done got %b want 1", bus.done); end
    endtask

    task automatic test_abort();
        logic [2:0] st;
        logic [EW-1:0] v;
        do_start(20, 8'h11);
        for (int c = 2; c <= 19; c++) begin
            tick();
            bus.err_flag[3] = (c == 13 || c == 14);
            bus.start       = (c == 7);
            bus.len_ctrl_in = (c == 7) ? 8'h77 : 8'h11;
            bus.abort       = (c == 17);
            if (c == 9) begin
                st = bus.state;
                nchk++; if (st !== 3'd2) begin nerr++; $display("FAIL settle_start_state got %0d want 2", st); end
                nchk++; if (bus.test_len_ctrl !== 8'h11) begin nerr++; $display("FAIL settle_start_len got %h want 11", bus.test_len_ctrl); end
            end
            if (c == 18) begin
                st = bus.state;
                v = cnt_of(3);
                nchk++; if (st !== 3'd0) begin nerr++; $display("FAIL abort_state got %0d want 0", st); end
                nchk++; if (bus.test_run_ctrl !== 1'b0) begin nerr++; $display("FAIL abort_run got %b want 0", bus.test_run_ctrl); end
                nchk++; if ({bus.busy, bus.done} !== 2'b00) begin nerr++; $display("FAIL abort_busy_done got %b want 00", {bus.busy, bus.done}); end
                nchk++; if (bus.gen_rst_n !== 1'b1) begin nerr++; $display("FAIL abort_gen_rst_n got %b want 1", bus.gen_rst_n); end
                nchk++; if (v !== EW'(1)) begin nerr++; $display("FAIL abort_cnt_kept got %0d want 1", v); end
            end
            if (c == 19) begin
                nchk++; if (bus.fail_mask !== 8'h08) begin nerr++; $display("FAIL abort_fail_mask got %h want 08", bus.fail_mask); end
            end
        end
        do_start(0, 8'h22);
        for (int c = 2; c <= 18; c++) tick();
        nchk++; if (bus.done !== 1'b1) begin nerr++; $display("FAIL coll_pre_done got %b want 1", bus.done); end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        st = bus.state;
        nchk++; if (st !== 3'd0) begin nerr++; $display("FAIL coll_state got %0d want 0", st); end
        nchk++; if (bus.gen_rst_n !== 1'b1) begin nerr++; $display("FAIL coll_gen_rst_n got %b want 1", bus.gen_rst_n); end
        nchk++; if ({bus.busy, bus.done} !== 2'b00) begin nerr++; $display("FAIL coll_busy_done got %b want 00", {bus.busy, bus.done}); end
    endtask

    task automatic test_async_reset();
        logic [2:0] st;
        logic [EW-1:0] v;
        do_start(20, 8'h99);
        for (int c = 2; c <= 34; c++) begin
            tick();
            bus.err_flag[5] = (c == 14 || c == 15);
        end
        st = bus.state;
        v = cnt_of(5);
        nchk++; if (st !== 3'd4) begin nerr++; $display("FAIL ar_pre_state got %0d want 4", st); end
        nchk++; if (v !== EW'(1)) begin nerr++; $display("FAIL ar_pre_cnt got %0d want 1", v); end
        #3;
        rst = 1'b1;
        #1;
        st = bus.state;
        nchk++; if (st !== 3'd0) begin nerr++; $display("FAIL ar_state got %0d want 0", st); end
        nchk++; if (bus.gen_rst_n !== 1'b0) begin nerr++; $display("FAIL ar_gen_rst_n got %b want 0", bus.gen_rst_n); end
        nchk++; if (bus.err_cnt !== '0) begin nerr++; $display("FAIL ar_err_cnt got %h want 0", bus.err_cnt); end
        nchk++; if ({bus.busy, bus.test_run_ctrl} !== 2'b00) begin nerr++; $display("FAIL ar_busy_run got %b want 00", {bus.busy, bus.test_run_ctrl}); end
        #2;
        rst = 1'b0;
        tick();
        st = bus.state;
        nchk++; if (bus.gen_rst_n !== 1'b1) begin nerr++; $display("FAIL ar_release_gen_rst_n got %b want 1", bus.gen_rst_n); end
        nchk++; if (st !== 3'd0) begin nerr++; $display("FAIL ar_release_state got %0d want 0", st); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_error_inject();
        test_saturation();
        test_zero_restart();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
